multicycle_control: RTL and testbench

Main control FSM for the multi-cycle RISC-V datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives every datapath enable and mux select, and drives the 3-bit `alu_op` consumed by the ALU control decoder. Supports add, and, sll, ori, lb, sb and bne. Memory accesses use a ready handshake, so fetch and data accesses may stall for any number of cycles.

---
 rtl/riscv_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_control.sv | 154 +++++++++++++++
 tb/tb_multicycle_control.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path: FSM state
// encoding, the opcodes the control FSM recognises, the ALUOp classes
// understood by the ALU control decoder, and the ALU operand selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ALU_WB = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WB = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    // Opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUOp classes shared with the ALU control decoder
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_ORI   = 3'b011;

    // ALU operand selects
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    // Dispatch target after DECODE; anything unrecognised traps.
    function automatic state_t dispatch(input logic [6:0] op);
        state_t s;
        case (op)
            OP_RTYPE:           s = S_EXEC_R;
            OP_IMM:             s = S_EXEC_I;
            OP_LOAD, OP_STORE:  s = S_ADDR;
            OP_BRANCH:          s = S_BRANCH;
            default:            s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RISC-V datapath. Sequences fetch,
// decode, execute, memory and write-back, and drives every datapath enable
// and select. Outputs are decoded from the current state, with pc_write /
// ir_write gated by mem_ready in FETCH and pc_write gated by alu_zero in
// BRANCH.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_source,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t           state_reg;
    state_t           state_next;
    state_t           out_state;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;

    // While reset is held the outputs present a quiescent FETCH so that no
    // in-flight memory access or register write survives into the reset cycle.
    assign out_state = reset ? S_FETCH : state_reg;
    assign state     = out_state;
    assign retired   = retired_reg;

    // Final cycle of every instruction bumps the retired counter.
    always_comb begin
        retire = 1'b0;
        case (state_reg)
            S_ALU_WB, S_MEM_WB, S_BRANCH: retire = 1'b1;
            S_MEM_WR:                     retire = mem_ready;
            default:                      retire = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_next = dispatch(opcode);
            S_EXEC_R: state_next = S_ALU_WB;
            S_EXEC_I: state_next = S_ALU_WB;
            S_ALU_WB: state_next = S_FETCH;
            S_ADDR:   state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB: state_next = S_FETCH;
            S_MEM_WR: state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH: state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    // Output decode from the presented state.
    always_comb begin
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        case (out_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                pc_write  = mem_ready & ~reset;
                ir_write  = mem_ready & ~reset;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALUOP_ORI;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
            end
            S_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALUOP_SUB;
                pc_source = 1'b1;
                pc_write  = ~alu_zero;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control. An instruction-level
// model expands each instruction (kind, fetch stalls, memory stalls, branch
// flag) into the per-cycle outputs it must produce and queues them; a monitor
// on the falling edge pops and compares against the DUT.
module tb_multicycle_control;

    localparam int CW = 4;

    typedef struct packed {
        logic [3:0]    st;
        logic          pcw;
        logic          pcs;
        logic          irw;
        logic          iod;
        logic          mrd;
        logic          mwr;
        logic          rw;
        logic          m2r;
        logic [1:0]    sa;
        logic [1:0]    sb;
        logic [2:0]    aop;
        logic          ill;
        logic [CW-1:0] ret;
    } exp_t;

    localparam int K_R = 0, K_I = 1, K_LB = 2, K_SB = 3, K_BNE = 4, K_ILL = 5, K_ABORT = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic          alu_zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write;
    logic          reg_write, mem_to_reg, illegal;
    logic [1:0]    alu_src_a, alu_src_b;
    logic [2:0]    alu_op;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    exp_t          sbq[$];
    int            n_vec = 0;
    int            n_bad = 0;
    int            n_instr = 0;
    logic [CW-1:0] exp_ret = '0;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            exp_t g;
            e = sbq.pop_front();
            g = '{st: state, pcw: pc_write, pcs: pc_source, irw: ir_write,
                  iod: i_or_d, mrd: mem_read, mwr: mem_write, rw: reg_write,
                  m2r: mem_to_reg, sa: alu_src_a, sb: alu_src_b, aop: alu_op,
                  ill: illegal, ret: retired};
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t: got st=%0d pcw=%b pcs=%b irw=%b iod=%b mrd=%b mwr=%b rw=%b m2r=%b sa=%b sb=%b aop=%b ill=%b ret=%0d, required st=%0d pcw=%b pcs=%b irw=%b iod=%b mrd=%b mwr=%b rw=%b m2r=%b sa=%b sb=%b aop=%b ill=%b ret=%0d",
                         $time, g.st, g.pcw, g.pcs, g.irw, g.iod, g.mrd, g.mwr, g.rw, g.m2r, g.sa, g.sb, g.aop, g.ill, g.ret,
                         e.st, e.pcw, e.pcs, e.irw, e.iod, e.mrd, e.mwr, e.rw, e.m2r, e.sa, e.sb, e.aop, e.ill, e.ret);
            end
        end
    end

    function automatic exp_t base(input int st);
        exp_t e;
        e     = '0;
        e.st  = 4'(st);
        e.ret = exp_ret;
        return e;
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(1));
    endfunction

    // Apply one cycle of inputs and queue the outputs they must produce.
    task automatic cyc(input exp_t e, input logic rdy, input logic az, input logic rst_i);
        mem_ready = rdy;
        alu_zero  = az;
        reset     = rst_i;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t e;
        e     = base(0);
        e.mrd = 1'b1;
        e.sb  = 2'b01;
        cyc(e, rnd1(), rnd1(), 1'b1);
        exp_ret = '0;
    endtask

    function automatic logic [6:0] illegal_op();
        logic [6:0] op;
        do begin
            op = 7'($urandom);
        end while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
                   op == 7'b0100011 || op == 7'b1100011);
        return op;
    endfunction

    // One instruction: fs fetch stalls, ms memory stalls (or trap/abort
    // length), az = branch comparison result.
    task automatic run_instr(input int kind, input int fs, input int ms, input logic az,
                             input logic [6:0] ill_op);
        exp_t e;
        logic rdy;
        int   n;
        n = 0;
        for (int i = 0; i <= fs; i++) begin
            rdy    = (i == fs);
            opcode = 7'($urandom);
            e      = base(0);
            e.mrd  = 1'b1;
            e.sb   = 2'b01;
            e.pcw  = rdy;
            e.irw  = rdy;
            cyc(e, rdy, rnd1(), 1'b0);
            n++;
        end
        case (kind)
            K_R:          opcode = 7'b0110011;
            K_I:          opcode = 7'b0010011;
            K_LB:         opcode = 7'b0000011;
            K_SB, K_ABORT: opcode = 7'b0100011;
            K_BNE:        opcode = 7'b1100011;
            default:      opcode = ill_op;
        endcase
        e    = base(1);
        e.sa = 2'b01;
        e.sb = 2'b10;
        cyc(e, rnd1(), rnd1(), 1'b0);
        n++;
        case (kind)
            K_R, K_I: begin
                e     = base(kind == K_R ? 2 : 3);
                e.sa  = 2'b10;
                e.sb  = (kind == K_R) ? 2'b00 : 2'b10;
                e.aop = (kind == K_R) ? 3'b010 : 3'b011;
                cyc(e, rnd1(), rnd1(), 1'b0);
                e    = base(4);
                e.rw = 1'b1;
                cyc(e, rnd1(), rnd1(), 1'b0);
                exp_ret++;
                n += 2;
            end
            K_LB, K_SB, K_ABORT: begin
                e    = base(5);
                e.sa = 2'b10;
                e.sb = 2'b10;
                cyc(e, rnd1(), rnd1(), 1'b0);
                n++;
                for (int i = 0; i <= ms; i++) begin
                    rdy   = (i == ms) && (kind != K_ABORT);
                    e     = base(kind == K_LB ? 6 : 8);
                    e.iod = 1'b1;
                    e.mrd = (kind == K_LB);
                    e.mwr = (kind != K_LB);
                    cyc(e, rdy, rnd1(), 1'b0);
                    n++;
                end
                if (kind == K_LB) begin
                    e     = base(7);
                    e.rw  = 1'b1;
                    e.m2r = 1'b1;
                    cyc(e, rnd1(), rnd1(), 1'b0);
                    n++;
                    exp_ret++;
                end else if (kind == K_SB) begin
                    exp_ret++;
                end else begin
                    // Reset lands while the store is still waiting on memory.
                    e     = base(0);
                    e.mrd = 1'b1;
                    e.sb  = 2'b01;
                    cyc(e, 1'b0, rnd1(), 1'b1);
                    exp_ret = '0;
                    n++;
                end
            end
            K_BNE: begin
                e     = base(9);
                e.sa  = 2'b10;
                e.aop = 3'b001;
                e.pcs = 1'b1;
                e.pcw = ~az;
                cyc(e, rnd1(), az, 1'b0);
                exp_ret++;
                n++;
            end
            default: begin
                for (int i = 0; i < ms; i++) begin
                    e     = base(10);
                    e.ill = 1'b1;
                    cyc(e, rnd1(), rnd1(), 1'b0);
                    n++;
                end
                do_reset();
                n++;
            end
        endcase
        n_instr++;
        $display("instr %0d kind=%0d op=%b fetch_stall=%0d mem_stall=%0d zero=%b cycles=%0d retired_exp=%0d",
                 n_instr, kind, opcode, fs, ms, az, n, exp_ret);
    endtask

    initial begin
        int k;
        // Unchecked first edge to leave the power-up unknown state.
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Directed cases
        run_instr(K_R,   0, 0, 1'b0, 7'd0);
        run_instr(K_LB,  0, 3, 1'b0, 7'd0);
        run_instr(K_BNE, 0, 0, 1'b0, 7'd0);
        run_instr(K_BNE, 0, 0, 1'b1, 7'd0);
        run_instr(K_SB,  0, 0, 1'b0, 7'd0);
        run_instr(K_ILL, 0, 20, 1'b0, 7'b1111111);
        run_instr(K_R,   0, 0, 1'b0, 7'd0);
        run_instr(K_ABORT, 1, 2, 1'b0, 7'd0);
        for (int i = 0; i < 17; i++) begin
            run_instr(K_I, 0, 0, 1'b0, 7'd0);
        end

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 19);
            if (k >= 5 && k <= 17) k = $urandom_range(0, 4);
            else if (k == 18) k = K_ILL;
            else if (k == 19) k = K_ABORT;
            run_instr(k, $urandom_range(0, 3), (k == K_ILL) ? $urandom_range(1, 6) : $urandom_range(0, 3),
                      rnd1(), illegal_op());
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
